// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// ALUControl encodings, arbiter state encodings and the datapath width.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_t;

    // Any encoding with the top bit set is outside the ALUControl set.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, subtract, and, or. Illegal encodings
// yield a zero result and raise the illegal flag.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);

    always_comb begin
        result  = '0;
        illegal = is_illegal_op(alu_control);
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, round-robin or fixed
// priority, holding each registered result until its owner takes it.
// Optional macro ALU_ARB_PERF_EN adds per-requester 32-bit grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1
`endif
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              prio_q;
    logic              owner_q;
    logic [DATA_W-1:0] result_q;
    logic              err_q;

    logic              rsp_hs;
    logic              can_accept;
    logic              winner;
    logic              accept;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_illegal;

    // A new op may enter in the same cycle the held result is taken,
    // which gives back-to-back throughput. Ready is held low while in reset.
    always_comb begin
        rsp_hs     = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
        can_accept = rst && ((state_q == ST_IDLE) || rsp_hs);
        if (req0_valid && req1_valid) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
        end else begin
            winner = !req0_valid;
        end
        req0_ready = can_accept && req0_valid && !winner;
        req1_ready = can_accept && req1_valid && winner;
        accept     = req0_ready || req1_ready;
        alu_a      = winner ? req1_a  : req0_a;
        alu_b      = winner ? req1_b  : req0_b;
        alu_op     = winner ? req1_op : req0_op;
    end

    alu u_alu (
        .a           (alu_a),
        .b           (alu_b),
        .alu_control (alu_op),
        .result      (alu_result),
        .illegal     (alu_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: if (rsp_hs && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp0_valid  = (state_q == ST_RESP) && !owner_q;
        rsp1_valid  = (state_q == ST_RESP) && owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_err    = rsp1_valid && err_q;
    end

    // Result, owner and priority only move on an accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            result_q <= alu_result;
            err_q    <= alu_illegal;
            owner_q  <= winner;
            if (FIXED_PRIO == 0) begin
                prio_q <= !winner;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (req1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule
